// File: rtl/simon_auto_player.sv
// Autonomous player for the b12 colour-sequence game: records each displayed
// sequence, then replays it on the keys with a hold-until-echo handshake.
module simon_auto_player #(
  parameter int unsigned MAX_LEN     = 32,
  parameter int unsigned TIMEOUT     = 1023,
  parameter int unsigned FAULT_ROUND = 0
) (
  input  logic       clock_i,
  input  logic       nreset_i,
  input  logic       go_i,
  input  logic [3:0] nl_i,
  input  logic       nloss_i,
  output logic       start_o,
  output logic [3:0] k_o,
  output logic       busy_o,
  output logic       won_o,
  output logic       lost_o,
  output logic [5:0] round_o
);

  localparam int unsigned AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    StIdle, StStart, StWatch, StPress, StRelease, StWaitWin, StWon, StLost
  } state_e;

  state_e          state_q, state_d;
  logic [5:0]      round_q, round_d, wp_q, wp_d, rp_q, rp_d;
  logic [3:0]      k_q, k_d, nl_prev_q;
  logic            start_q, start_d, busy_q, busy_d, won_q, won_d, lost_q, lost_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic [1:0]      mem_q [MAX_LEN];
  logic            mem_we;

  logic [1:0] enc, first_col, next_col;
  logic       nl_onehot, nl_edge, win_pat, in_game, fault_now;
  logic [5:0] rp_next, wp_inc;

  function automatic logic [3:0] key_of(input logic [1:0] c);
    return 4'b0001 << c;
  endfunction

  always_comb begin
    enc       = 2'd0;
    nl_onehot = 1'b1;
    case (nl_i)
      4'b0001: enc = 2'd0;
      4'b0010: enc = 2'd1;
      4'b0100: enc = 2'd2;
      4'b1000: enc = 2'd3;
      default: nl_onehot = 1'b0;
    endcase
  end

  assign nl_edge   = nl_onehot && (nl_prev_q == 4'b0000);
  assign win_pat   = (nl_i == 4'b1111);
  assign rp_next   = rp_q + 6'd1;
  assign wp_inc    = wp_q + 6'd1;
  // Slot 0 is being written this very cycle when round 1 completes.
  assign first_col = (wp_q == 6'd0) ? enc : mem_q[0];
  assign next_col  = mem_q[rp_next[AW-1:0]];
  assign fault_now = (FAULT_ROUND != 0) && (round_q == 6'(FAULT_ROUND));
  assign in_game   = (state_q == StStart) || (state_q == StWatch) || (state_q == StPress) ||
                     (state_q == StRelease) || (state_q == StWaitWin);

  always_comb begin
    state_d = state_q;
    round_d = round_q;
    wp_d    = wp_q;
    rp_d    = rp_q;
    k_d     = k_q;
    start_d = 1'b0;
    busy_d  = busy_q;
    won_d   = won_q;
    lost_d  = lost_q;
    tmo_d   = tmo_q;
    mem_we  = 1'b0;

    if (in_game && nloss_i) begin
      state_d = StLost;
      lost_d  = 1'b1;
      busy_d  = 1'b0;
      k_d     = 4'b0000;
    end else if (win_pat && (state_q == StWatch || state_q == StRelease)) begin
      state_d = StWon;
      won_d   = 1'b1;
      busy_d  = 1'b0;
      k_d     = 4'b0000;
    end else begin
      case (state_q)
        StIdle, StWon, StLost: begin
          if (go_i) begin
            state_d = StStart;
            start_d = 1'b1;
            round_d = 6'd1;
            wp_d    = 6'd0;
            busy_d  = 1'b1;
            won_d   = 1'b0;
            lost_d  = 1'b0;
            k_d     = 4'b0000;
          end
        end
        StStart: state_d = StWatch;
        StWatch: begin
          if (nl_edge) begin
            mem_we = 1'b1;
            wp_d   = wp_inc;
            if (wp_inc == round_q) begin
              state_d = StPress;
              rp_d    = 6'd0;
              tmo_d   = '0;
              k_d     = key_of(fault_now ? first_col + 2'd1 : first_col);
            end
          end
        end
        StPress: begin
          if (nl_i != 4'b0000) begin
            state_d = StRelease;
            k_d     = 4'b0000;
          end else if (tmo_q == TW'(TIMEOUT - 1)) begin
            state_d = StLost;
            lost_d  = 1'b1;
            busy_d  = 1'b0;
            k_d     = 4'b0000;
          end else begin
            tmo_d = tmo_q + 1'b1;
          end
        end
        StRelease: begin
          if (nl_i == 4'b0000) begin
            if (rp_next < round_q) begin
              state_d = StPress;
              rp_d    = rp_next;
              tmo_d   = '0;
              k_d     = key_of(next_col);
            end else if (round_q == 6'(MAX_LEN)) begin
              state_d = StWaitWin;
              tmo_d   = '0;
            end else begin
              state_d = StWatch;
              round_d = round_q + 6'd1;
              wp_d    = 6'd0;
            end
          end
        end
        StWaitWin: begin
          if (win_pat) begin
            state_d = StWon;
            won_d   = 1'b1;
            busy_d  = 1'b0;
          end else if (tmo_q == TW'(TIMEOUT - 1)) begin
            state_d = StLost;
            lost_d  = 1'b1;
            busy_d  = 1'b0;
          end else begin
            tmo_d = tmo_q + 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clock_i or negedge nreset_i) begin
    if (!nreset_i) begin
      state_q   <= StIdle;
      round_q   <= 6'd0;
      wp_q      <= 6'd0;
      rp_q      <= 6'd0;
      k_q       <= 4'b0000;
      nl_prev_q <= 4'b0000;
      start_q   <= 1'b0;
      busy_q    <= 1'b0;
      won_q     <= 1'b0;
      lost_q    <= 1'b0;
      tmo_q     <= '0;
    end else begin
      state_q   <= state_d;
      round_q   <= round_d;
      wp_q      <= wp_d;
      rp_q      <= rp_d;
      k_q       <= k_d;
      nl_prev_q <= nl_i;
      start_q   <= start_d;
      busy_q    <= busy_d;
      won_q     <= won_d;
      lost_q    <= lost_d;
      tmo_q     <= tmo_d;
    end
  end

  always_ff @(posedge clock_i) begin
    if (mem_we) mem_q[wp_q[AW-1:0]] <= enc;
  end

  assign start_o = start_q;
  assign k_o     = k_q;
  assign busy_o  = busy_q;
  assign won_o   = won_q;
  assign lost_o  = lost_q;
  assign round_o = round_q;

endmodule

// File: tb/tb_simon_auto_player.sv
// Directed bench: the bench plays the game side (LED display, echo, loss/win)
// against a default player and a second one with a fault in round 3.
module tb_simon_auto_player;

  logic       clk = 1'b0;
  logic       nreset, go, nloss;
  logic [3:0] nl;
  logic       start_a, busy_a, won_a, lost_a, start_f, busy_f, won_f, lost_f;
  logic [3:0] k_a, k_f, k_sel;
  logic [5:0] round_a, round_f;
  logic       use_flt;
  logic [1:0] seq [32];
  int         checks = 0;
  int         failures = 0;

  always #5 clk = ~clk;

  simon_auto_player u_dut (
    .clock_i(clk), .nreset_i(nreset), .go_i(go), .nl_i(nl), .nloss_i(nloss),
    .start_o(start_a), .k_o(k_a), .busy_o(busy_a), .won_o(won_a), .lost_o(lost_a),
    .round_o(round_a)
  );

  simon_auto_player #(.MAX_LEN(32), .TIMEOUT(1023), .FAULT_ROUND(3)) u_flt (
    .clock_i(clk), .nreset_i(nreset), .go_i(go), .nl_i(nl), .nloss_i(nloss),
    .start_o(start_f), .k_o(k_f), .busy_o(busy_f), .won_o(won_f), .lost_o(lost_f),
    .round_o(round_f)
  );

  assign k_sel = use_flt ? k_f : k_a;

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic apply_reset;
    nreset = 1'b0; go = 1'b0; nl = 4'b0000; nloss = 1'b0; use_flt = 1'b0;
    repeat (2) tick;
    nreset = 1'b1;
    tick;
  endtask

  // Returns on the first negedge with the player in WATCH.
  task automatic begin_game;
    go = 1'b1; tick;
    go = 1'b0; tick;
  endtask

  task automatic show_colour(input logic [1:0] c);
    nl = 4'b0001 << c; tick;
    nl = 4'b0000;      tick;
  endtask

  // Acts as the game's echo for n key presses; counts wrong keys and stuck keys.
  task automatic replay(input int n, output int bad);
    logic [3:0] want;
    bad = 0;
    for (int i = 0; i < n; i++) begin
      int w = 0;
      while (k_sel == 4'b0000 && w < 50) begin
        tick;
        w++;
      end
      want = 4'b0001 << seq[i];
      if (k_sel != want) bad++;
      nl = k_sel; tick;
      if (k_sel != 4'b0000) bad++;
      nl = 4'b0000; tick;
    end
  endtask

  task automatic play_round(input int n, output int bad);
    for (int i = 0; i < n; i++) show_colour(seq[i]);
    replay(n, bad);
  endtask

  task automatic test_reset;
    apply_reset;
    checks++;
    if ({start_a, k_a, busy_a, won_a, lost_a, round_a} !== 14'd0) begin
      failures++;
      $display("FAIL reset_outputs: got %b want 0", {start_a, k_a, busy_a, won_a, lost_a, round_a});
    end
    checks++;
    if ({start_f, k_f, busy_f, won_f, lost_f, round_f} !== 14'd0) begin
      failures++;
      $display("FAIL reset_outputs_flt: got %b want 0", {start_f, k_f, busy_f, won_f, lost_f, round_f});
    end
  endtask

  task automatic test_first_round;
    apply_reset;
    for (int i = 0; i < 32; i++) seq[i] = 2'(i);
    go = 1'b1; tick;
    checks++;
    if ({start_a, busy_a, round_a} !== {1'b1, 1'b1, 6'd1}) begin
      failures++;
      $display("FAIL start_pulse: got start=%b busy=%b round=%0d want 1 1 1", start_a, busy_a, round_a);
    end
    go = 1'b0; tick;
    checks++;
    if (start_a !== 1'b0) begin
      failures++;
      $display("FAIL start_one_cycle: got %b want 0", start_a);
    end
    show_colour(2'd0);
    repeat (3) tick;
    checks++;
    if (k_a !== 4'b0001) begin
      failures++;
      $display("FAIL first_key_held: got %b want 0001", k_a);
    end
    nl = 4'b0001; tick;
    checks++;
    if (k_a !== 4'b0000) begin
      failures++;
      $display("FAIL key_release_on_echo: got %b want 0000", k_a);
    end
    nl = 4'b0000; tick;
    checks++;
    if (round_a !== 6'd2) begin
      failures++;
      $display("FAIL round_advance: got %0d want 2", round_a);
    end
  endtask

  task automatic test_full_game;
    int bad, total;
    apply_reset;
    for (int i = 0; i < 32; i++) seq[i] = 2'((i ^ (i >> 2)) & 3);
    begin_game;
    total = 0;
    for (int r = 1; r <= 32; r++) begin
      play_round(r, bad);
      total += bad;
    end
    checks++;
    if (total !== 0) begin
      failures++;
      $display("FAIL full_game_keys: got %0d bad presses want 0", total);
    end
    checks++;
    if ({won_a, lost_a, busy_a, round_a} !== {1'b0, 1'b0, 1'b1, 6'd32}) begin
      failures++;
      $display("FAIL waitwin_state: got won=%b lost=%b busy=%b round=%0d want 0 0 1 32",
               won_a, lost_a, busy_a, round_a);
    end
    nl = 4'b1111; tick;
    nl = 4'b0000;
    checks++;
    if ({won_a, lost_a, busy_a, k_a, round_a} !== {1'b1, 1'b0, 1'b0, 4'b0000, 6'd32}) begin
      failures++;
      $display("FAIL game_won: got won=%b lost=%b busy=%b k=%b round=%0d want 1 0 0 0000 32",
               won_a, lost_a, busy_a, k_a, round_a);
    end
    go = 1'b1; tick;
    go = 1'b0;
    checks++;
    if ({start_a, won_a, round_a} !== {1'b1, 1'b0, 6'd1}) begin
      failures++;
      $display("FAIL restart_from_won: got start=%b won=%b round=%0d want 1 0 1",
               start_a, won_a, round_a);
    end
    tick;
  endtask

  task automatic test_fault;
    int bad1, bad2;
    apply_reset;
    use_flt = 1'b1;
    seq[0] = 2'd2; seq[1] = 2'd0; seq[2] = 2'd1;
    begin_game;
    play_round(1, bad1);
    play_round(2, bad2);
    checks++;
    if (bad1 + bad2 !== 0) begin
      failures++;
      $display("FAIL fault_early_rounds: got %0d bad presses want 0", bad1 + bad2);
    end
    for (int i = 0; i < 3; i++) show_colour(seq[i]);
    checks++;
    if (k_f !== 4'b1000) begin
      failures++;
      $display("FAIL fault_key: got %b want 1000", k_f);
    end
    checks++;
    if (k_a !== 4'b0100) begin
      failures++;
      $display("FAIL nofault_key: got %b want 0100", k_a);
    end
    nloss = 1'b1; tick;
    nloss = 1'b0;
    checks++;
    if ({lost_f, busy_f, won_f, k_f} !== {1'b1, 1'b0, 1'b0, 4'b0000}) begin
      failures++;
      $display("FAIL fault_loss: got lost=%b busy=%b won=%b k=%b want 1 0 0 0000",
               lost_f, busy_f, won_f, k_f);
    end
    use_flt = 1'b0;
  endtask

  task automatic test_timeout;
    apply_reset;
    begin_game;
    nl = 4'b0100; tick;
    nl = 4'b0000;
    checks++;
    if (k_a !== 4'b0100) begin
      failures++;
      $display("FAIL timeout_press: got %b want 0100", k_a);
    end
    repeat (1022) tick;
    checks++;
    if ({lost_a, k_a} !== {1'b0, 4'b0100}) begin
      failures++;
      $display("FAIL timeout_early: got lost=%b k=%b want 0 0100", lost_a, k_a);
    end
    tick;
    checks++;
    if ({lost_a, busy_a, k_a} !== {1'b1, 1'b0, 4'b0000}) begin
      failures++;
      $display("FAIL timeout_lost: got lost=%b busy=%b k=%b want 1 0 0000", lost_a, busy_a, k_a);
    end
  endtask

  task automatic test_reset_mid_game;
    apply_reset;
    begin_game;
    nl = 4'b0100; tick;
    nl = 4'b0000;
    #2 nreset = 1'b0;
    #1;
    checks++;
    if ({k_a, busy_a, round_a} !== {4'b0000, 1'b0, 6'd0}) begin
      failures++;
      $display("FAIL async_reset: got k=%b busy=%b round=%0d want 0000 0 0", k_a, busy_a, round_a);
    end
    tick;
    nreset = 1'b1; tick;
    go = 1'b1; tick;
    go = 1'b0;
    checks++;
    if ({start_a, busy_a, round_a} !== {1'b1, 1'b1, 6'd1}) begin
      failures++;
      $display("FAIL restart_after_reset: got start=%b busy=%b round=%0d want 1 1 1",
               start_a, busy_a, round_a);
    end
    tick;
  endtask

  task automatic test_non_onehot;
    apply_reset;
    begin_game;
    nl = 4'b0101; tick;
    nl = 4'b0100; tick;
    nl = 4'b0000; tick;
    checks++;
    if ({k_a, busy_a} !== {4'b0000, 1'b1}) begin
      failures++;
      $display("FAIL no_capture: got k=%b busy=%b want 0000 1", k_a, busy_a);
    end
    nl = 4'b0010; tick;
    nl = 4'b0000;
    checks++;
    if (k_a !== 4'b0010) begin
      failures++;
      $display("FAIL capture_after_ignore: got %b want 0010", k_a);
    end
    tick;
    nl = 4'b0010; tick;
    nl = 4'b0000; tick;
    checks++;
    if (round_a !== 6'd2) begin
      failures++;
      $display("FAIL round_after_ignore: got %0d want 2", round_a);
    end
  endtask

  task automatic test_win_in_watch;
    apply_reset;
    begin_game;
    nl = 4'b1111; tick;
    nl = 4'b0000;
    checks++;
    if ({won_a, lost_a, busy_a} !== {1'b1, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL win_in_watch: got won=%b lost=%b busy=%b want 1 0 0", won_a, lost_a, busy_a);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish want finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset;
    test_first_round;
    test_full_game;
    test_fault;
    test_timeout;
    test_reset_mid_game;
    test_non_onehot;
    test_win_in_watch;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/simon_auto_player.md
Name: simon_auto_player

Overview:
- Autonomous player for the b12 colour-sequence game. It drives the game's `start` and `k[3:0]` inputs and observes its `nl[3:0]` and `nloss` outputs.
- It records each displayed colour sequence, then replays it on the keys using a hold-until-echo handshake.
- It sits beside the game controller in the system-level bench and self-test harness, closing the key/LED loop without a human.

Parameters:
- MAX_LEN, 32: maximum sequence length; equals the game's memory depth.
- TIMEOUT, 1023: cycles to wait for the game's LED echo of a held key before declaring a loss.
- FAULT_ROUND, 0: round (1..MAX_LEN) in which the first key of replay is deliberately wrong; 0 disables fault injection.

Ports:
- clock, input, 1: rising-edge clock.
- nreset, input, 1: asynchronous active-low reset.
- go, input, 1: request a new game; sampled while the player is in IDLE, WON or LOST.
- nl, input, 4: game LED outputs; bit i on means colour i.
- nloss, input, 1: game loss LED.
- start, output, 1: one-cycle start pulse to the game.
- k, output, 4: one-hot key outputs to the game; all zero when idle.
- busy, output, 1: high while a game is in progress.
- won, output, 1: sticky; set when the win pattern is seen.
- lost, output, 1: sticky; set on nloss or timeout.
- round, output, 6: current round length (1..MAX_LEN); 0 in IDLE.

Behaviour:
- Reset (asynchronous, nreset=0):
  - start=0, k=0, busy=0, won=0, lost=0, round=0, state=IDLE.
  - Sequence store contents are don't-care.
  - Reset mid-game takes effect immediately, including releasing any held key.
- Storage and encoding:
  - Sequence store is MAX_LEN x 2 bits, with a write pointer wp and a replay pointer rp (6 bits each).
  - A colour is captured only when nl is one-hot. Encoding: nl=0001->0, 0010->1, 0100->2, 1000->3.
  - An edge means nl goes from 0000 to one-hot on consecutive cycles.
  - Non-one-hot nonzero values are ignored for capture.
- State machine (registered outputs, one transition per clock):
  - IDLE: go=1 -> START.
  - START: start=1 for exactly one cycle; round=1, wp=0, busy=1, won=0, lost=0 -> WATCH.
  - WATCH:
    - On each edge: store colour at wp, wp=wp+1.
    - When wp reaches round after a capture -> PRESS with rp=0.
  - PRESS:
    - Drive k = onehot(store[rp]).
    - When FAULT_ROUND==round and rp==0, drive onehot(store[0]+1 mod 4) instead.
    - Hold k until nl!=0 (the echo), then k=0 in the following cycle -> RELEASE.
    - A timeout counter starts at entry; after TIMEOUT cycles with no echo -> LOST.
  - RELEASE:
    - Wait for nl==0000.
    - Then, if rp+1 < round: rp=rp+1 -> PRESS.
    - Otherwise round=round+1, wp=0 -> WATCH.
    - If round was already MAX_LEN, go -> WAITWIN instead.
  - WAITWIN: nl==1111 -> WON. The same TIMEOUT rule applies (-> LOST).
  - WON: won=1, busy=0, k=0; go=1 -> START.
  - LOST: lost=1, busy=0, k=0; go=1 -> START.
- Global events:
  - nloss=1 in any non-IDLE/WON/LOST state -> LOST next cycle; k is forced to 0 that cycle.
  - nl==1111 in WATCH or RELEASE -> WON.
  - Priority: nloss > win pattern > normal transitions.
- Only one k bit is ever high. k changes only on PRESS entry and on echo.
- round saturates at MAX_LEN. wp never exceeds round.

Test Plan:
- Directed scenarios, run against a b12 game instance plus a 32x2 memory model with one-cycle read latency:
  1. Reset, then go=1 with memory filled 0,1,2,3,...
     - start pulses once.
     - Player captures colour 0, presses k=0001 until nl=0001, then releases.
     - round becomes 2.
  2. Full game with FAULT_ROUND=0 and TIMEOUT=1023: all 32 rounds pass, won=1, lost=0, round=32, and nloss is never asserted.
  3. FAULT_ROUND=3 and memory[0]=2: in round 3 the player presses k=1000. The game raises nloss, giving lost=1, busy=0, k=0000 one cycle later.
  4. Game held in G0 (no start delivered) after the player enters PRESS: with no echo for 1023 cycles, lost=1 and k=0000.
  5. nreset pulsed low while k=0100 is held: k=0000 and busy=0 immediately. After release, go restarts cleanly with round=1.
  6. nl driven 0101 (non-one-hot) in WATCH: no capture, wp unchanged. A following 0000->0010 is captured as colour 1.
